// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave endpoint: default frame length and bit-counter sizing.
package spi_pkg;

   localparam int DEFAULT_WIDTH = 8;

   // Counter must represent 0..w inclusive so the saturated "frame done" value is distinct.
   function automatic int cntBits(input int w);
      return $clog2(w + 1);
   endfunction

   localparam int DEFAULT_CNT_W = cntBits(DEFAULT_WIDTH);

endpackage

// File: rtl/slave_bit_counter.sv
// Frame bit counter on SCLK falling edge: cleared while CS is high or in reset, saturates at WIDTH.
// lastBit flags the edge that completes a byte; done blocks further sampling until CS rises.
module slave_bit_counter
   import spi_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   localparam int CW = cntBits(WIDTH)
) (
   input  logic          SCLK,
   input  logic          reset,
   input  logic          CS,
   output logic [CW-1:0] bitCnt,
   output logic          lastBit,
   output logic          done
);

   always_comb begin
      done    = (bitCnt == CW'(WIDTH));
      lastBit = (bitCnt == CW'(WIDTH - 1));
   end

   always_ff @(negedge SCLK) begin
      if (reset || CS) begin
         bitCnt <= '0;
      end else if (!done) begin
         bitCnt <= bitCnt + CW'(1);
      end
   end

endmodule

// File: rtl/slave.sv
// SPI slave endpoint: one LSB-first byte in on MOSI and out on MISO per CS-low frame, clocked by SCLK only.
// Received byte updates on the frame's last falling edge; edges beyond WIDTH are ignored until CS rises.
module slave
   import spi_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             SCLK,
   input  logic             reset,
   input  logic [WIDTH-1:0] slaveDataToSend,
   output logic [WIDTH-1:0] slaveDataReceived,
   input  logic             CS,
   input  logic             MOSI,
   output logic             MISO
);

   localparam int CW = cntBits(WIDTH);

   logic [WIDTH-1:0] txReg;
   logic [WIDTH-1:0] rxShift;
   logic [CW-1:0]    bitCnt;
   logic             lastBit;
   logic             cntDone;

   slave_bit_counter #(
      .WIDTH (WIDTH)
   ) u_bitCounter (
      .SCLK    (SCLK),
      .reset   (reset),
      .CS      (CS),
      .bitCnt  (bitCnt),
      .lastBit (lastBit),
      .done    (cntDone)
   );

   always_ff @(negedge SCLK) begin
      if (reset) begin
         txReg             <= '0;
         rxShift           <= '0;
         slaveDataReceived <= '0;
      end else if (CS) begin
         // Transmit byte is captured only while idle, so it stays frozen for the whole frame.
         txReg <= slaveDataToSend;
      end else if (!cntDone) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (bitCnt == CW'(i)) begin
               rxShift[i] <= MOSI;
            end
         end
         if (lastBit) begin
            slaveDataReceived <= {MOSI, rxShift[WIDTH-2:0]};
         end
      end
   end

   // Bit 0 is presented as soon as CS falls, before the first falling edge of the frame.
   always_comb begin
      MISO = 1'b0;
      if (!CS) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (bitCnt == CW'(i)) begin
               MISO = txReg[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_slave.sv
// Self-checking bench for the SPI slave: acts as master on a free-running SCLK and checks frames against a byte-level model.
module tb_slave;

   logic       SCLK = 1'b0;
   logic       reset;
   logic       CS;
   logic       MOSI;
   logic       MISO;
   logic [7:0] slaveDataToSend;
   logic [7:0] slaveDataReceived;

   int errors = 0;
   int checks = 0;
   logic [7:0] expRecv;

   always #5 SCLK = ~SCLK;

   slave #(
      .WIDTH (8)
   ) dut (
      .SCLK              (SCLK),
      .reset             (reset),
      .slaveDataToSend   (slaveDataToSend),
      .slaveDataReceived (slaveDataReceived),
      .CS                (CS),
      .MOSI              (MOSI),
      .MISO              (MISO)
   );

   // Master side of one frame: load tx during one idle falling edge, then drive nEdges bits.
   // MISO is collected away from the falling edge, i.e. the value the master sees at that edge.
   task automatic runFrame(input logic [7:0] txByte, input logic [7:0] rxByte, input int nEdges,
                           input int changeAt, input logic [7:0] newTx, output logic [31:0] collected);
      collected = '0;
      @(posedge SCLK); #1;
      slaveDataToSend = txByte;
      CS = 1'b1;
      @(negedge SCLK);
      @(posedge SCLK); #1;
      CS = 1'b0;
      for (int k = 0; k < nEdges; k++) begin
         MOSI = (k < 8) ? rxByte[k] : 1'($urandom);
         if (k == changeAt) slaveDataToSend = newTx;
         #1;
         collected[k] = MISO;
         @(negedge SCLK);
         @(posedge SCLK); #1;
      end
      CS = 1'b1;
   endtask

   // Reference: a frame of >= 8 edges delivers rxByte and returns the byte latched at frame start,
   // padded with zeros for any extra edges; shorter frames leave the received byte untouched.
   function automatic logic [31:0] expMiso(input logic [7:0] txByte, input int nEdges);
      logic [31:0] v;
      v = '0;
      for (int k = 0; k < nEdges && k < 8; k++) v[k] = txByte[k];
      return v;
   endfunction

   task automatic test_reset;
      reset = 1'b1;
      CS = 1'b1;
      MOSI = 1'b1;
      slaveDataToSend = 8'hA5;
      repeat (2) @(negedge SCLK);
      @(posedge SCLK); #1;
      checks++;
      if (slaveDataReceived !== 8'h00) begin
         errors++;
         $display("FAIL reset_recv: got %h want 00", slaveDataReceived);
      end
      checks++;
      if (MISO !== 1'b0) begin
         errors++;
         $display("FAIL reset_miso_idle: got %b want 0", MISO);
      end
      // Reset overrides CS: the tx register must not have captured A5.
      CS = 1'b0;
      #1;
      checks++;
      if (MISO !== 1'b0) begin
         errors++;
         $display("FAIL reset_miso_cs_low: got %b want 0", MISO);
      end
      @(negedge SCLK);
      @(posedge SCLK); #1;
      checks++;
      if (MISO !== 1'b0 || slaveDataReceived !== 8'h00) begin
         errors++;
         $display("FAIL reset_override: miso %b recv %h want 0 / 00", MISO, slaveDataReceived);
      end
      reset = 1'b0;
      CS = 1'b1;
      expRecv = 8'h00;
   endtask

   task automatic checkFrame(input string name, input logic [7:0] txByte, input logic [7:0] rxByte,
                             input int nEdges, input int changeAt, input logic [7:0] newTx);
      logic [31:0] got;
      logic [31:0] want;
      runFrame(txByte, rxByte, nEdges, changeAt, newTx, got);
      if (nEdges >= 8) expRecv = rxByte;
      want = expMiso(txByte, nEdges);
      checks++;
      if (slaveDataReceived !== expRecv) begin
         errors++;
         $display("FAIL %s_recv: got %h want %h", name, slaveDataReceived, expRecv);
      end
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s_miso: got %h want %h", name, got, want);
      end
   endtask

   task automatic test_frame1;
      checkFrame("frame1", 8'b00001001, 8'b01010011, 8, -1, 8'h00);
   endtask

   task automatic test_back_to_back;
      checkFrame("b2b_0", 8'h98, 8'h3C, 8, -1, 8'h00);
      checkFrame("b2b_1", 8'hFF, 8'h55, 8, -1, 8'h00);
      checkFrame("b2b_2", 8'h98, 8'h5F, 8, -1, 8'h00);
      for (int i = 0; i < 20; i++) begin
         checkFrame("b2b_rand", 8'($urandom), 8'($urandom), 8, -1, 8'h00);
      end
   endtask

   task automatic test_extra_clocks;
      checkFrame("extra10", 8'hC3, 8'h96, 10, -1, 8'h00);
      for (int i = 0; i < 4; i++) begin
         checkFrame("extra_long", 8'($urandom), 8'($urandom), 24, -1, 8'h00);
      end
   endtask

   task automatic test_abort;
      logic [7:0] rx;
      checkFrame("pre_abort", 8'h5A, 8'hE1, 8, -1, 8'h00);
      checkFrame("abort3", 8'h77, 8'h1E, 3, -1, 8'h00);
      for (int i = 0; i < 4; i++) begin
         rx = 8'($urandom);
         checkFrame("abort_rand", 8'($urandom), rx, 1 + int'($urandom_range(6)), -1, 8'h00);
      end
      checkFrame("post_abort", 8'h3C, 8'hA7, 8, -1, 8'h00);
   endtask

   task automatic test_mid_change;
      checkFrame("mid_change", 8'h98, 8'h21, 8, 3, 8'h00);
      checkFrame("after_change", 8'h00, 8'hB4, 8, -1, 8'h00);
      checkFrame("mid_change_rand", 8'($urandom), 8'($urandom), 8, 5, 8'($urandom));
   endtask

   initial begin
      test_reset();
      test_frame1();
      test_back_to_back();
      test_extra_clocks();
      test_abort();
      test_mid_change();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
